// File: rtl/score_display_if.sv
`default_nettype none
// ============================================================================
// Module      : score_display_if
// Description : Bundle of game-state inputs and display/status outputs shared
//               between the score_display consumer and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface score_display_if #(
  parameter int SCORE_W = 11
);
  logic               frame_tick;
  logic               rdy;
  logic               lost;
  logic [SCORE_W-1:0] totalscore;
  logic [6:0]         HEX0;
  logic [6:0]         HEX1;
  logic [6:0]         HEX2;
  logic [6:0]         HEX3;
  logic [SCORE_W-1:0] high_score;
  logic               new_record;
  logic               busy;

  // Environment side: drives game state, observes the display
  modport master (
    output frame_tick, rdy, lost, totalscore,
    input  HEX0, HEX1, HEX2, HEX3, high_score, new_record, busy
  );

  // Display side: consumes game state, drives the display
  modport slave (
    input  frame_tick, rdy, lost, totalscore,
    output HEX0, HEX1, HEX2, HEX3, high_score, new_record, busy
  );
endinterface
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Converts the active score (running score while a game is live,
//               session high score otherwise) to four BCD digits with a
//               sequential double-dabble engine, drives four active-low
//               seven-segment displays, tracks the high score and blinks the
//               display while the game is over.
//               Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading
//               zero digits above HEX0.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
  parameter int SCORE_W      = 11,
  parameter int BLINK_FRAMES = 30
) (
  input  wire logic     Clk,
  input  wire logic     Reset,
  score_display_if.slave bus
);

  localparam int         CNT_W     = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int         BLINK_W   = $clog2(BLINK_FRAMES + 1);
  localparam logic [6:0] C_SEG_BLK = 7'h7F;
  localparam logic [6:0] C_SEG_0   = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] C_RST_UP  = C_SEG_BLK;
`else
  localparam logic [6:0] C_RST_UP  = C_SEG_0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_load;
  logic               w_shift;
  logic               w_done;

  logic [SCORE_W-1:0] w_disp_val;
  logic [SCORE_W-1:0] r_shadow;
  logic [SCORE_W-1:0] r_bin;
  logic [15:0]        r_bcd;
  logic [15:0]        w_bcd_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic [15:0]        r_digits;

  logic               r_lost_q;
  logic               w_lost_rise;
  logic [SCORE_W-1:0] r_high_score;
  logic               r_new_record;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blank_phase;

  logic [6:0]         w_seg [4];
  logic [6:0]         w_hex [4];
  logic [6:0]         r_hex [4];

  // Live game (or game over) shows the running score; press-start shows the record
  assign w_disp_val  = (bus.rdy || bus.lost) ? bus.totalscore : r_high_score;
  assign w_lost_rise = bus.lost && !r_lost_q;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before shifting
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                  (r_bcd[4*gi +: 4] + 4'd3) : r_bcd[4*gi +: 4];
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state and control strobes
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_disp_val != r_shadow) begin
          w_load       = 1'b1;
          w_next_state = S_CONVERT;
        end
      end
      S_CONVERT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(SCORE_W - 1)) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Conversion datapath: load, shift {bcd,bin} left, then latch the digits
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shadow <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
    end else begin
      if (w_load) begin
        r_shadow <= w_disp_val;
        r_bin    <= w_disp_val;
        r_bcd    <= '0;
        r_cnt    <= '0;
      end
      if (w_shift) begin
        r_bcd <= {w_bcd_adj[14:0], r_bin[SCORE_W-1]};
        r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) r_digits <= r_bcd;
    end
  end

  // High score capture on the cycle the game first reports lost
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lost_q     <= 1'b0;
      r_high_score <= '0;
      r_new_record <= 1'b0;
    end else begin
      r_lost_q <= bus.lost;
      if (w_lost_rise) begin
        if (bus.totalscore > r_high_score) begin
          r_high_score <= bus.totalscore;
          r_new_record <= 1'b1;
        end else begin
          r_new_record <= 1'b0;
        end
      end
    end
  end

  // Blink timer: counts frames while lost, restarting from phase 0 on a new game over
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_blink_cnt   <= '0;
      r_blank_phase <= 1'b0;
    end else if (!bus.lost || w_lost_rise) begin
      r_blink_cnt   <= '0;
      r_blank_phase <= 1'b0;
    end else if (bus.frame_tick) begin
      if (r_blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blank_phase <= !r_blank_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Segment decode for each stored digit
  for (genvar gd = 0; gd < 4; gd++) begin : g_seg
    always_comb begin
      w_seg[gd] = C_SEG_BLK;
      case (r_digits[4*gd +: 4])
        4'd0: w_seg[gd] = 7'h40;
        4'd1: w_seg[gd] = 7'h79;
        4'd2: w_seg[gd] = 7'h24;
        4'd3: w_seg[gd] = 7'h30;
        4'd4: w_seg[gd] = 7'h19;
        4'd5: w_seg[gd] = 7'h12;
        4'd6: w_seg[gd] = 7'h02;
        4'd7: w_seg[gd] = 7'h78;
        4'd8: w_seg[gd] = 7'h00;
        4'd9: w_seg[gd] = 7'h10;
        default: w_seg[gd] = C_SEG_BLK;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank each upper digit while it and everything above it are zero
  logic w_lz3, w_lz2, w_lz1;
  assign w_lz3    = (r_digits[15:12] == 4'd0);
  assign w_lz2    = w_lz3 && (r_digits[11:8] == 4'd0);
  assign w_lz1    = w_lz2 && (r_digits[7:4] == 4'd0);
  assign w_hex[0] = w_seg[0];
  assign w_hex[1] = w_lz1 ? C_SEG_BLK : w_seg[1];
  assign w_hex[2] = w_lz2 ? C_SEG_BLK : w_seg[2];
  assign w_hex[3] = w_lz3 ? C_SEG_BLK : w_seg[3];
`else
  assign w_hex[0] = w_seg[0];
  assign w_hex[1] = w_seg[1];
  assign w_hex[2] = w_seg[2];
  assign w_hex[3] = w_seg[3];
`endif

  // Output register: blink blanking overrides the digit patterns
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hex[0] <= C_SEG_0;
      r_hex[1] <= C_RST_UP;
      r_hex[2] <= C_RST_UP;
      r_hex[3] <= C_RST_UP;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_hex[i] <= r_blank_phase ? C_SEG_BLK : w_hex[i];
      end
    end
  end

  assign bus.HEX0       = r_hex[0];
  assign bus.HEX1       = r_hex[1];
  assign bus.HEX2       = r_hex[2];
  assign bus.HEX3       = r_hex[3];
  assign bus.high_score = r_high_score;
  assign bus.new_record = r_new_record;
  assign bus.busy       = (r_state == S_CONVERT) || (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Self-checking bench for score_display. Stimulus pushes the
//               expected display word for every conversion into a queue; a
//               monitor pops and compares each time a conversion lands on HEX.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

  localparam int SCORE_W = 11;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  score_display_if #(.SCORE_W(SCORE_W)) bus ();

  score_display #(.SCORE_W(SCORE_W), .BLINK_FRAMES(30)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [27:0] sb [$];
  bit          rst_at_edge = 1'b0;
  bit          prev_busy   = 1'b0;
  bit          pending     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
      4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
      8: seg = 7'h00;  9: seg = 7'h10;  default: seg = 7'h7F;
    endcase
  endfunction

  // Expected {HEX3,HEX2,HEX1,HEX0} for a value shown without blink
  function automatic logic [27:0] exp_hex(input int v);
    logic [6:0] h3, h2, h1, h0;
    h0 = seg(v % 10);
    h1 = seg((v / 10) % 10);
    h2 = seg((v / 100) % 10);
    h3 = seg((v / 1000) % 10);
`ifdef LEADING_ZERO_BLANK_EN
    if (v < 1000) h3 = 7'h7F;
    if (v < 100)  h2 = 7'h7F;
    if (v < 10)   h1 = 7'h7F;
`endif
    return {h3, h2, h1, h0};
  endfunction

  function automatic logic [27:0] hex_now();
    return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  // Remember whether the last active edge was a reset edge
  always @(posedge Clk) rst_at_edge <= Reset;

  // Monitor: a conversion ending (busy falling, not by reset) updates HEX one edge later
  always @(negedge Clk) begin
    if (pending) begin
      pending = 1'b0;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected none", hex_now());
      end else begin
        check("sb_hex", {4'h0, hex_now()}, {4'h0, sb.pop_front()});
      end
    end
    if (prev_busy && !bus.busy && !rst_at_edge) pending = 1'b1;
    prev_busy = bus.busy;
  end

  task automatic wait_idle();
    int idle = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (!bus.busy) idle++; else idle = 0;
      if (idle >= 3) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: got busy expected idle within 300 cycles");
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    Reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.rdy        = 1'b0;
    bus.lost       = 1'b0;
    bus.totalscore = '0;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_hex",   {4'h0, hex_now()}, {4'h0, exp_hex(0)});
    check("rst_high",  32'(bus.high_score), 32'd0);
    check("rst_rec",   32'(bus.new_record), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // 0 -> 1234: busy for 12 cycles, HEX updates 14 cycles after the change
    bus.rdy        = 1'b1;
    bus.totalscore = 11'd1234;
    sb.push_back({7'h79, 7'h24, 7'h30, 7'h19});
    for (int i = 1; i <= 14; i++) begin
      @(negedge Clk);
      check($sformatf("lat_busy%0d", i), 32'(bus.busy), (i <= 12) ? 32'd1 : 32'd0);
      if (i == 13) check("lat_hex13", {4'h0, hex_now()}, {4'h0, exp_hex(0)});
      if (i == 14) check("lat_hex14", {4'h0, hex_now()}, {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
    end
    wait_idle();

    // Score 57, then game over: new record
    bus.totalscore = 11'd57;
    sb.push_back(exp_hex(57));
    wait_idle();
    bus.lost = 1'b1;
    @(negedge Clk);
    check("rec_high", 32'(bus.high_score), 32'd57);
    check("rec_flag", 32'(bus.new_record), 32'd1);

    // Blink: 29 ticks still visible, 30th blanks, 30 more unblank
    repeat (29) tick();
    check("blink29", {4'h0, hex_now()}, {4'h0, exp_hex(57)});
    tick();
    check("blink_off", {4'h0, hex_now()}, {4'h0, {4{7'h7F}}});
    repeat (30) tick();
    check("blink_on", {4'h0, hex_now()}, {4'h0, exp_hex(57)});

    // Back to press-start: shows high score 57, no blink, no conversion needed
    bus.rdy  = 1'b0;
    bus.lost = 1'b0;
    repeat (3) @(negedge Clk);
    check("ps_busy", 32'(bus.busy), 32'd0);
    check("ps_hex",  {4'h0, hex_now()}, {4'h0, exp_hex(57)});

    // Next game ends at 12: no record
    bus.rdy        = 1'b1;
    bus.totalscore = 11'd12;
    sb.push_back(exp_hex(12));
    wait_idle();
    bus.lost = 1'b1;
    @(negedge Clk);
    check("norec_high", 32'(bus.high_score), 32'd57);
    check("norec_flag", 32'(bus.new_record), 32'd0);
    bus.rdy  = 1'b0;
    bus.lost = 1'b0;
    sb.push_back(exp_hex(57));
    wait_idle();

    // 5 -> 9 during the third CONVERT cycle: 5 shown first, then 9
    bus.rdy        = 1'b1;
    bus.totalscore = 11'd5;
    sb.push_back(exp_hex(5));
    repeat (3) @(negedge Clk);
    bus.totalscore = 11'd9;
    sb.push_back(exp_hex(9));
    wait_idle();
    check("hex0_9", 32'(bus.HEX0), 32'h10);

    // Reset mid-conversion aborts; 8 then converts normally
    bus.totalscore = 11'd3;
    repeat (4) @(negedge Clk);
    Reset          = 1'b1;
    bus.totalscore = 11'd8;
    @(negedge Clk);
    Reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hex",  {4'h0, hex_now()}, {4'h0, exp_hex(0)});
    check("abort_high", 32'(bus.high_score), 32'd0);
    check("abort_rec",  32'(bus.new_record), 32'd0);
    sb.push_back(exp_hex(8));
    wait_idle();
    check("hex0_8", 32'(bus.HEX0), 32'h00);

    repeat (3) @(negedge Clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
